dn_mem_arbiter: RTL and testbench
=================================

# dn_mem_arbiter

Controller that shares one synchronous RAM port between the ioctl download stream and the system CPU, and sequences the system reset around downloads. Sits in the emu wrapper between the ioctl bus, the clock-enable divider domain and `system`. It replaces direct `reset | ioctl_download` gating with a counted reset hold. It also applies ioctl_wait back-pressure while a downloaded byte is being committed.

## Interface
Parameters:
- MEM_AW, 16: RAM address width in bytes.
- WR_CYCLES, 2: cycles mem_we is held per write; range 1–15.
- RD_LAT, 1: RAM read latency in cycles; range 1–3.
- RESET_HOLD, 64: cycles sys_reset stays high after download ends or after reset_n release.
- DN_INDEX, 0: ioctl_index value accepted; bytes with any other index are dropped.

Ports:
- clk_sys, in, 1: system clock. Single clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- ioctl_download, in, 1: download in progress.
- ioctl_wr, in, 1: one-cycle byte strobe.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- ioctl_index, in, 8: download target index.
- ioctl_wait, out, 1: back-pressure to the ioctl source.
- cpu_req, in, 1: CPU access request; held until cpu_ack.
- cpu_we, in, 1: 1 = write.
- cpu_addr, in, MEM_AW: CPU address.
- cpu_din, in, 8: CPU write data.
- cpu_dout, out, 8: read data; valid with cpu_ack.
- cpu_ack, out, 1: one-cycle completion pulse.
- mem_cs, out, 1: RAM select.
- mem_we, out, 1: RAM write enable.
- mem_addr, out, MEM_AW: RAM address.
- mem_din, out, 8: RAM write data.
- mem_dout, in, 8: RAM read data.
- sys_reset, out, 1: active-high reset to `system`.
- dn_overflow, out, 1: sticky flag. Set when an accepted byte's address is ≥ 2^MEM_AW.

## Operation
- States:
  - HOLD: counter runs; sys_reset=1.
  - IDLE
  - CPU_ACC
  - DL_IDLE
  - DL_WR
- Reset entry: all state goes to HOLD and the counter is loaded with RESET_HOLD.
- HOLD:
  - Counter decrements each cycle. At 0 → IDLE.
  - If ioctl_download=1 → DL_IDLE immediately; the counter is reloaded when the download ends.
- IDLE:
  - ioctl_download=1 has priority → DL_IDLE.
  - Otherwise, cpu_req=1 → CPU_ACC.
- CPU_ACC:
  - Drive mem_cs, mem_addr=cpu_addr; drive mem_we/mem_din for writes.
  - Write: hold WR_CYCLES cycles. Read: wait RD_LAT cycles, then capture mem_dout into cpu_dout.
  - Pulse cpu_ack, then → IDLE.
  - An in-flight access always completes, even if ioctl_download rises; the request only then moves to DL_IDLE.
- DL_IDLE:
  - sys_reset=1. The CPU is never served.
  - On ioctl_download=0 → HOLD, counter reloaded.
- One-entry byte buffer:
  - Captures {addr, data} on any ioctl_wr with ioctl_download=1 and ioctl_index==DN_INDEX, in any state.
  - Capture sets pending and ioctl_wait.
  - Bytes with a non-matching index are ignored and do not raise ioctl_wait.
- DL_IDLE with pending:
  - If addr[24:MEM_AW]≠0: set dn_overflow, clear pending, no RAM write.
  - Else → DL_WR.
- DL_WR:
  - mem_cs=mem_we=1 for WR_CYCLES cycles.
  - Then clear pending, drop ioctl_wait, and → DL_IDLE.
- dn_overflow clears only on reset_n or on the rising edge of ioctl_download.
- ioctl_wr while pending=1 is a protocol violation. The new byte overwrites the buffer. The bench asserts this never happens.

## Timing
- Reset values: ioctl_wait=0, cpu_dout=0, cpu_ack=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0, sys_reset=1, dn_overflow=0.
- All outputs are registered.
- ioctl_wait rises the cycle after the ioctl_wr strobe.
- Download write latency:
  - Strobe to mem_we: 2 cycles when idle.
  - ioctl_wait high for WR_CYCLES+2 cycles.
- CPU write: cpu_ack at cycle WR_CYCLES+1 after cpu_req is sampled.
- CPU read: cpu_ack at cycle RD_LAT+2 after cpu_req is sampled.
- sys_reset:
  - Rises the cycle after ioctl_download rises.
  - Falls exactly RESET_HOLD+1 cycles after ioctl_download falls, provided no write is in flight.
  - A write in flight when ioctl_download falls finishes first, and the hold starts after it.
- Back-to-back CPU requests: one idle cycle between cpu_ack and the next mem_cs.
- Counter width: $clog2(RESET_HOLD+1). WR/RD counters are 4 bits.

## Configuration
- DN_CHECKSUM_EN defined:
  - Adds output dn_checksum[15:0], reset to 0.
  - Cleared on the rising edge of ioctl_download.
  - Adds each written byte, zero-extended, modulo 2^16. Overflow-dropped bytes are excluded.
- DN_CHECKSUM_EN undefined: the port and the adder are absent. All other behaviour is identical.

## Structure
- Package dn_mem_pkg holds:
  - the state enum: ST_HOLD, ST_IDLE, ST_CPU_ACC, ST_DL_IDLE, ST_DL_WR;
  - the WR/RD counter width constant.
- One sub-module, dn_reset_seq: the RESET_HOLD down-counter plus sys_reset register, with load/busy interface.
- The arbiter FSM and the byte buffer stay in the top.

## Test plan
- Reset release with no download → sys_reset falls after 64 cycles; CPU write 0xA5 to 0x0010, then read back → cpu_dout=0xA5, ack latencies 3 and 3.
- Download of 4 bytes 0x11..0x14 at addresses 0..3, index 0, wr every 8 cycles:
  - RAM holds 0x11..0x14;
  - ioctl_wait is high 4 cycles per byte;
  - dn_checksum=0x004A when enabled.
- Byte with ioctl_index=1 during a download → no mem_we, ioctl_wait stays 0.
- Byte at address 0x10000 with MEM_AW=16 → dn_overflow=1, no mem_we; a new download clears the flag.
- ioctl_download rises during a CPU read → the read completes with cpu_ack, then sys_reset=1, and no further cpu_ack while downloading.
- reset_n asserted mid-DL_WR → mem_we=0 and ioctl_wait=0 immediately, sys_reset=1, and HOLD restarts.

Source files
------------

// File: rtl/dn_mem_pkg.sv
// dn_mem_pkg: shared types and constants for the download/CPU memory arbiter.
// The optional download checksum is enabled by defining DN_CHECKSUM_EN.
package dn_mem_pkg;

   // Width of the per-access WR/RD cycle counters (WR_CYCLES up to 15).
   localparam int CTR_W = 4;

   // Arbiter states.
   typedef enum logic [2:0] {
      ST_HOLD,
      ST_IDLE,
      ST_CPU_ACC,
      ST_DL_IDLE,
      ST_DL_WR
   } state_t;

endpackage

// File: rtl/dn_reset_seq.sv
// dn_reset_seq: counted system-reset hold. A load restarts the RESET_HOLD
// countdown with sys_reset high; a hold keeps sys_reset high and freezes the
// count; otherwise the count runs and sys_reset drops as it reaches zero.
module dn_reset_seq
   import dn_mem_pkg::*;
#(
   parameter int RESET_HOLD = 64
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_hold,
   output logic o_sys_reset,
   output logic o_expire
);

   localparam int CNT_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_sys_reset;

   // Countdown and registered sys_reset; reset entry behaves like a load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt       <= CNT_W'(RESET_HOLD);
         r_sys_reset <= 1'b1;
      end else if (i_load) begin
         r_cnt       <= CNT_W'(RESET_HOLD);
         r_sys_reset <= 1'b1;
      end else if (i_hold) begin
         r_sys_reset <= 1'b1;
      end else begin
         if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
         r_sys_reset <= (r_cnt > CNT_W'(1));
      end
   end

   assign o_sys_reset = r_sys_reset;
   // Last counting cycle: the FSM leaves HOLD on the same edge sys_reset drops.
   assign o_expire    = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/dn_mem_arbiter.sv
// dn_mem_arbiter: shares one synchronous RAM port between the ioctl download
// stream and the CPU, and sequences sys_reset around downloads.
// Optional feature: define DN_CHECKSUM_EN to add the dn_checksum output.
module dn_mem_arbiter
   import dn_mem_pkg::*;
#(
   parameter int MEM_AW     = 16,
   parameter int WR_CYCLES  = 2,
   parameter int RD_LAT     = 1,
   parameter int RESET_HOLD = 64,
   parameter int DN_INDEX   = 0
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic              ioctl_wait,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [MEM_AW-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_ack,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout,
   output logic              sys_reset,
   output logic              dn_overflow
`ifdef DN_CHECKSUM_EN
   ,
   output logic [15:0]       dn_checksum
`endif
);

   state_t              r_state;
   logic [CTR_W-1:0]    r_cnt;
   logic                r_acc_wr;
   logic                r_pending;
   logic                r_wait;
   logic [24:0]         r_buf_addr;
   logic [7:0]          r_buf_data;
   logic [7:0]          r_cpu_dout;
   logic                r_cpu_ack;
   logic                r_mem_cs;
   logic                r_mem_we;
   logic [MEM_AW-1:0]   r_mem_addr;
   logic [7:0]          r_mem_din;
   logic                r_ovf;
   logic                r_dl_d;

   logic                w_capture;
   logic                w_buf_ovf;
   logic                w_dl_rise;
   logic                w_rs_load;
   logic                w_rs_hold;
   logic                w_rs_expire;
   logic                w_sys_reset;

   assign w_capture = ioctl_wr & ioctl_download & (ioctl_index == 8'(DN_INDEX));
   assign w_buf_ovf = (r_buf_addr >> MEM_AW) != 25'd0;
   assign w_dl_rise = ioctl_download & ~r_dl_d;
   // Download finished and nothing left to commit: restart the reset hold.
   assign w_rs_load = (r_state == ST_DL_IDLE) & ~r_pending & ~ioctl_download;

   // Keep sys_reset high whenever the next state is a download state.
   always_comb begin
      w_rs_hold = 1'b0;
      case (r_state)
         ST_HOLD, ST_IDLE:     w_rs_hold = ioctl_download;
         ST_DL_IDLE, ST_DL_WR: w_rs_hold = 1'b1;
         default:              w_rs_hold = 1'b0;
      endcase
   end

   dn_reset_seq #(
      .RESET_HOLD (RESET_HOLD)
   ) u_reset_seq (
      .i_clk       (clk_sys),
      .i_rst_n     (reset_n),
      .i_load      (w_rs_load),
      .i_hold      (w_rs_hold),
      .o_sys_reset (w_sys_reset),
      .o_expire    (w_rs_expire)
   );

   // Byte buffer payload; only meaningful while r_pending is set.
   always_ff @(posedge clk_sys) begin
      if (w_capture) begin
         r_buf_addr <= ioctl_addr;
         r_buf_data <= ioctl_dout;
      end
   end

   // Arbiter FSM with registered RAM/CPU outputs and the buffer control bits.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_HOLD;
         r_cnt      <= '0;
         r_acc_wr   <= 1'b0;
         r_pending  <= 1'b0;
         r_wait     <= 1'b0;
         r_cpu_dout <= 8'd0;
         r_cpu_ack  <= 1'b0;
         r_mem_cs   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= 8'd0;
         r_ovf      <= 1'b0;
         r_dl_d     <= 1'b0;
      end else begin
         r_cpu_ack <= 1'b0;
         r_dl_d    <= ioctl_download;
         if (w_dl_rise)
            r_ovf <= 1'b0;
         case (r_state)
            ST_HOLD: begin
               if (ioctl_download)
                  r_state <= ST_DL_IDLE;
               else if (w_rs_expire)
                  r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               // The ack cycle is skipped so a request still held from the
               // previous access is not served twice.
               if (ioctl_download) begin
                  r_state <= ST_DL_IDLE;
               end else if (cpu_req && !r_cpu_ack) begin
                  r_state    <= ST_CPU_ACC;
                  r_mem_cs   <= 1'b1;
                  r_mem_we   <= cpu_we;
                  r_acc_wr   <= cpu_we;
                  r_mem_addr <= cpu_addr;
                  r_mem_din  <= cpu_din;
                  r_cnt      <= cpu_we ? CTR_W'(WR_CYCLES) : CTR_W'(RD_LAT);
               end
            end
            ST_CPU_ACC: begin
               if (r_acc_wr) begin
                  if (r_cnt == CTR_W'(1)) begin
                     r_mem_cs  <= 1'b0;
                     r_mem_we  <= 1'b0;
                     r_cpu_ack <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt - CTR_W'(1);
                  end
               end else begin
                  if (r_cnt == '0) begin
                     r_cpu_dout <= mem_dout;
                     r_mem_cs   <= 1'b0;
                     r_cpu_ack  <= 1'b1;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt - CTR_W'(1);
                  end
               end
            end
            ST_DL_IDLE: begin
               // A pending byte is committed before the download end is honoured.
               if (r_pending) begin
                  if (w_buf_ovf) begin
                     r_ovf     <= 1'b1;
                     r_pending <= 1'b0;
                     r_wait    <= 1'b0;
                  end else begin
                     r_state    <= ST_DL_WR;
                     r_mem_cs   <= 1'b1;
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= r_buf_addr[MEM_AW-1:0];
                     r_mem_din  <= r_buf_data;
                     r_cnt      <= CTR_W'(WR_CYCLES);
                  end
               end else if (!ioctl_download) begin
                  r_state <= ST_HOLD;
               end
            end
            ST_DL_WR: begin
               // WR_CYCLES of mem_we, then one release cycle before ioctl_wait drops.
               if (r_cnt == '0) begin
                  r_pending <= 1'b0;
                  r_wait    <= 1'b0;
                  r_state   <= ST_DL_IDLE;
               end else begin
                  r_cnt <= r_cnt - CTR_W'(1);
                  if (r_cnt == CTR_W'(1)) begin
                     r_mem_cs <= 1'b0;
                     r_mem_we <= 1'b0;
                  end
               end
            end
            default: r_state <= ST_HOLD;
         endcase
         // A new byte always lands in the buffer, overwriting any pending one.
         if (w_capture) begin
            r_pending <= 1'b1;
            r_wait    <= 1'b1;
         end
      end
   end

`ifdef DN_CHECKSUM_EN
   logic [15:0] r_csum;

   // Running sum of bytes actually committed to RAM in the current download.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         r_csum <= 16'd0;
      else if (w_dl_rise)
         r_csum <= 16'd0;
      else if (r_state == ST_DL_IDLE && r_pending && !w_buf_ovf)
         r_csum <= r_csum + {8'd0, r_buf_data};
   end

   assign dn_checksum = r_csum;
`endif

   assign ioctl_wait  = r_wait;
   assign cpu_dout    = r_cpu_dout;
   assign cpu_ack     = r_cpu_ack;
   assign mem_cs      = r_mem_cs;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_din     = r_mem_din;
   assign sys_reset   = w_sys_reset;
   assign dn_overflow = r_ovf;

endmodule

// File: tb/tb_dn_mem_arbiter.sv
// tb_dn_mem_arbiter: directed and randomized bench for dn_mem_arbiter with a
// behavioural RAM and a reference memory/checksum model.
module tb_dn_mem_arbiter;

   localparam int MEM_AW     = 16;
   localparam int WR_CYCLES  = 2;
   localparam int RD_LAT     = 1;
   localparam int RESET_HOLD = 64;

   logic              clk_sys = 1'b0;
   logic              reset_n;
   logic              ioctl_download;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [7:0]        ioctl_index;
   logic              ioctl_wait;
   logic              cpu_req;
   logic              cpu_we;
   logic [MEM_AW-1:0] cpu_addr;
   logic [7:0]        cpu_din;
   logic [7:0]        cpu_dout;
   logic              cpu_ack;
   logic              mem_cs;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic              sys_reset;
   logic              dn_overflow;
`ifdef DN_CHECKSUM_EN
   logic [15:0]       dn_checksum;
`endif

   int errors = 0;
   int checks = 0;

   logic [7:0]  ref_mem [int];
   int          written_q [$];
   logic [15:0] csum_model;

   always #5 clk_sys = ~clk_sys;

   dn_mem_arbiter #(
      .MEM_AW     (MEM_AW),
      .WR_CYCLES  (WR_CYCLES),
      .RD_LAT     (RD_LAT),
      .RESET_HOLD (RESET_HOLD),
      .DN_INDEX   (0)
   ) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .ioctl_wait     (ioctl_wait),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_din        (cpu_din),
      .cpu_dout       (cpu_dout),
      .cpu_ack        (cpu_ack),
      .mem_cs         (mem_cs),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .sys_reset      (sys_reset),
      .dn_overflow    (dn_overflow)
`ifdef DN_CHECKSUM_EN
      ,
      .dn_checksum    (dn_checksum)
`endif
   );

   // Synchronous RAM, read latency of one cycle.
   logic [7:0] ram [0:65535];
   logic [7:0] rd_q;
   always @(posedge clk_sys) begin
      if (mem_cs && mem_we)  ram[mem_addr] <= mem_din;
      if (mem_cs && !mem_we) rd_q <= ram[mem_addr];
   end
   assign mem_dout = rd_q;

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One CPU access; lat is the number of edges from request to visible ack (0 = timeout).
   task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] din,
                             input bit dl_mid, output logic [7:0] dout, output int lat);
      cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_req = 1'b1;
      lat = 0; dout = 8'd0;
      for (int n = 1; n <= 20; n++) begin
         tick;
         if (dl_mid && n == 1) ioctl_download = 1'b1;
         if (cpu_ack) begin
            lat = n;
            dout = cpu_dout;
            break;
         end
      end
      cpu_req = 1'b0;
      tick;
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
      logic [7:0] d;
      int lat;
      cpu_access(1'b1, addr, data, 1'b0, d, lat);
      chk("cpu_wr_latency", lat, WR_CYCLES + 1);
      ref_mem[int'(addr)] = data;
      written_q.push_back(int'(addr));
   endtask

   task automatic cpu_read_chk(input logic [15:0] addr);
      logic [7:0] d;
      int lat;
      cpu_access(1'b0, addr, 8'd0, 1'b0, d, lat);
      chk("cpu_rd_latency", lat, RD_LAT + 2);
      chk("cpu_rd_data", d, ref_mem[int'(addr)]);
   endtask

   // One download byte followed by a 7-cycle observation window.
   task automatic dl_send(input logic [24:0] addr, input logic [7:0] data, input logic [7:0] idx);
      bit acc, inr;
      int wcnt, wecnt, fw, fwe;
      logic [15:0] wa;
      logic [7:0] wd;
      acc = (idx == 8'd0);
      inr = (addr < 25'h10000);
      chk("wait_low_before_wr", ioctl_wait, 0);
      ioctl_addr = addr; ioctl_dout = data; ioctl_index = idx; ioctl_wr = 1'b1;
      tick;
      ioctl_wr = 1'b0;
      wcnt = 0; wecnt = 0; fw = 0; fwe = 0; wa = 16'd0; wd = 8'd0;
      for (int k = 1; k <= 7; k++) begin
         if (ioctl_wait) begin
            wcnt++;
            if (fw == 0) fw = k;
         end
         if (mem_we) begin
            wecnt++;
            if (fwe == 0) begin
               fwe = k; wa = mem_addr; wd = mem_din;
            end
         end
         tick;
      end
      if (acc && inr) begin
         chk("dl_wait_cycles", wcnt, WR_CYCLES + 2);
         chk("dl_we_cycles", wecnt, WR_CYCLES);
         chk("dl_wait_rise", fw, 1);
         chk("dl_we_start", fwe, 2);
         chk("dl_we_addr", wa, addr[15:0]);
         chk("dl_we_data", wd, data);
         ref_mem[int'(addr)] = data;
         written_q.push_back(int'(addr));
         csum_model = csum_model + 16'(data);
      end else begin
         chk("dl_drop_no_we", wecnt, 0);
         if (!acc) chk("dl_drop_no_wait", wcnt, 0);
      end
   endtask

   task automatic dl_start;
      chk("sysrst_low_before_dl", sys_reset, 0);
      ioctl_download = 1'b1;
      csum_model = 16'd0;
      tick;
      chk("sysrst_rise", sys_reset, 1);
      tick;
   endtask

   task automatic dl_end;
      ioctl_download = 1'b0;
      repeat (RESET_HOLD) tick;
      chk("sysrst_hold_end", sys_reset, 1);
      tick;
      chk("sysrst_fall", sys_reset, 0);
   endtask

   initial begin
      logic [7:0] d;
      int lat;
      logic [15:0] a;

      reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
      ioctl_dout = '0; ioctl_index = '0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_din = '0; csum_model = 16'd0;
      repeat (3) tick;

      chk("rst_ioctl_wait", ioctl_wait, 0);
      chk("rst_cpu_dout", cpu_dout, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_sys_reset", sys_reset, 1);
      chk("rst_dn_overflow", dn_overflow, 0);
`ifdef DN_CHECKSUM_EN
      chk("rst_checksum", dn_checksum, 0);
`endif

      // Reset release: sys_reset held for RESET_HOLD edges.
      reset_n = 1'b1;
      repeat (RESET_HOLD - 1) tick;
      chk("por_hold", sys_reset, 1);
      tick;
      chk("por_fall", sys_reset, 0);

      // CPU write then read back.
      cpu_write(16'h0010, 8'hA5);
      cpu_read_chk(16'h0010);

      // Download of four bytes, a foreign-index byte, then random bytes.
      dl_start;
      for (int i = 0; i < 4; i++) dl_send(25'(i), 8'h11 + 8'(i), 8'd0);
`ifdef DN_CHECKSUM_EN
      chk("checksum_4b", dn_checksum, 16'h004A);
`endif
      dl_send(25'd5, 8'h77, 8'd1);
      for (int i = 0; i < 5; i++)
         dl_send(25'($urandom_range(16, 65535)), 8'($urandom), 8'd0);
`ifdef DN_CHECKSUM_EN
      chk("checksum_rand", dn_checksum, csum_model);
`endif
      for (int i = 0; i < 4; i++) chk("ram_dl_byte", ram[16'(i)], 8'h11 + 8'(i));
      dl_end;
      for (int i = 0; i < 4; i++) cpu_read_chk(16'(i));

      // Out-of-range byte sets the sticky overflow flag; a new download clears it.
      dl_start;
      chk("ovf_clear_start", dn_overflow, 0);
      dl_send(25'h10000, 8'h5A, 8'd0);
      chk("ovf_set", dn_overflow, 1);
      dl_end;
      chk("ovf_sticky", dn_overflow, 1);
      dl_start;
      chk("ovf_cleared_new_dl", dn_overflow, 0);

      // reset_n asserted while a download byte is being written.
      ioctl_addr = 25'd0; ioctl_dout = 8'hEE; ioctl_index = 8'd0; ioctl_wr = 1'b1;
      tick;
      ioctl_wr = 1'b0;
      tick;
      chk("dlwr_we_active", mem_we, 1);
      reset_n = 1'b0;
      ioctl_download = 1'b0;
      #1;
      chk("abort_mem_we", mem_we, 0);
      chk("abort_ioctl_wait", ioctl_wait, 0);
      chk("abort_sys_reset", sys_reset, 1);
      tick; tick;
      reset_n = 1'b1;
      repeat (RESET_HOLD - 1) tick;
      chk("abort_hold", sys_reset, 1);
      tick;
      chk("abort_hold_fall", sys_reset, 0);
      cpu_read_chk(16'd0);

      // Download rising during a CPU read: read completes, then CPU is locked out.
      cpu_access(1'b0, 16'd2, 8'd0, 1'b1, d, lat);
      chk("dlmid_rd_latency", lat, RD_LAT + 2);
      chk("dlmid_rd_data", d, ref_mem[2]);
      chk("dlmid_sysrst", sys_reset, 1);
      begin
         int acks;
         acks = 0;
         cpu_we = 1'b0; cpu_addr = 16'd3; cpu_req = 1'b1;
         for (int i = 0; i < 20; i++) begin
            tick;
            if (cpu_ack) acks++;
         end
         cpu_req = 1'b0;
         chk("dlmid_no_ack", acks, 0);
      end
      dl_end;

      // Randomized CPU traffic against the reference memory.
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            cpu_write(16'($urandom_range(0, 65535)), 8'($urandom));
         end else begin
            a = 16'(written_q[$urandom_range(0, written_q.size() - 1)]);
            cpu_read_chk(a);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
